ex_mdu: RTL

Multi-cycle RV32M multiply/divide unit attached beside the combinational execute stage. It accepts one M-extension operation (opcode OP, funct7 0000001) per start pulse. It holds the pipeline through a pause request while it computes, then issues a single-cycle register write-back. Data width is parametrised, and an optional single-cycle multiplier is selected at compile time.

---
 rtl/ex_mdu_pkg.sv | 14 +
 rtl/ex_mdu_iter_core.sv | 68 ++++++
 rtl/ex_mdu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared RV32M funct3 codes for the multiply/divide unit.
// Imported by ex_mdu and ex_mdu_iter_core; holds no state.
package ex_mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ex_mdu_iter_core.sv
// ex_mdu_iter_core: shared one-bit-per-cycle shift-add / restoring
// shift-subtract datapath on unsigned magnitudes.
// Ports: i_clk, i_rst (async, active-high), i_load (init from i_a/i_b,
// clear counter), i_step (advance one bit), i_div (mode at load),
// o_acc_nxt (accumulator value after this step), o_last (final step).
module ex_mdu_iter_core
    import ex_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc_nxt,
    output logic              o_last
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_div;
    logic [CNT_W-1:0]  r_cnt;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [2*XLEN-1:0] w_div_nxt;

    // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; the shifted-out
    // bit widens the trial remainder so the borrow is exact.
    assign w_rsh     = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_rsh - {1'b0, r_opnd};
    assign w_ge      = ~w_diff[XLEN];
    assign w_div_nxt = {(w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_ge};

    assign o_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
    assign o_last    = (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_cnt  <= '0;
            r_acc  <= {{XLEN{1'b0}}, (i_div ? i_a : i_b)};
            r_opnd <= i_div ? i_b : i_a;
        end else if (i_step) begin
            r_acc  <= o_acc_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV32M multiply/divide unit beside the execute stage.
// Ports: clk, rst (async, active-high), start/funct3/operand1/operand2/rd
// issue an op in IDLE, flush aborts IDLE/CALC; busy, pause_signal hold
// the pipeline; regs_write_en/addr/data form a one-cycle write-back.
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            pause_signal,
    output logic            regs_write_en,
    output logic [4:0]      regs_write_addr,
    output logic [XLEN-1:0] regs_write_data
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          r_state;
    logic [2:0]      r_f3;
    logic            r_neg;
    logic [4:0]      r_rd;

    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast_mul;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_fast_res;
    logic            w_accept;
    logic            w_load;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic            w_last;

    // Applies the result sign and picks the architectural half.
    // For divides acc holds {remainder, quotient}.
    function automatic logic [XLEN-1:0] sel_res(
        input logic [2:0]        f3,
        input logic              neg,
        input logic [2*XLEN-1:0] acc
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = neg ? -acc : acc;
        q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        unique case (f3)
            F3_MUL:                      sel_res = p[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel_res = p[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             sel_res = q;
            F3_REM, F3_REMU:             sel_res = r;
            default:                     sel_res = '0;
        endcase
    endfunction

    assign w_a_neg = operand1[XLEN-1] &&
                     (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    assign w_b_neg = operand2[XLEN-1] &&
                     (funct3 inside {F3_MULH, F3_DIV, F3_REM});
    assign w_a_abs = w_a_neg ? -operand1 : operand1;
    assign w_b_abs = w_b_neg ? -operand2 : operand2;
    // Remainder follows the dividend; everything else the product sign.
    assign w_neg   = (funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0 = funct3[2] && (operand2 == '0);
    assign w_ovf  = (funct3 inside {F3_DIV, F3_REM}) &&
                    (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (operand2 == '1);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_prod     = {{XLEN{1'b0}}, w_a_abs} * {{XLEN{1'b0}}, w_b_abs};
    assign w_fast_mul = ~funct3[2];
    assign w_mul_res  = sel_res(funct3, w_neg, w_prod);
`else
    assign w_fast_mul = 1'b0;
    assign w_mul_res  = '0;
`endif

    // funct3[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        w_fast_res = w_mul_res;
        if (w_div0)
            w_fast_res = funct3[1] ? operand1 : '1;
        else if (w_ovf)
            w_fast_res = funct3[1] ? '0 : operand1;
    end

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_load   = w_accept && !(w_div0 || w_ovf || w_fast_mul);

    assign busy         = (r_state != S_IDLE);
    assign pause_signal = w_accept || (r_state == S_CALC);

    ex_mdu_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_load),
        .i_step    (r_state == S_CALC),
        .i_div     (funct3[2]),
        .i_a       (w_a_abs),
        .i_b       (w_b_abs),
        .o_acc_nxt (w_acc_nxt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_f3            <= '0;
            r_neg           <= 1'b0;
            r_rd            <= '0;
            regs_write_en   <= 1'b0;
            regs_write_addr <= '0;
            regs_write_data <= '0;
        end else begin
            regs_write_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3  <= funct3;
                        r_neg <= w_neg;
                        r_rd  <= rd;
                        if (w_load) begin
                            r_state <= S_CALC;
                        end else begin
                            r_state         <= S_DONE;
                            regs_write_en   <= 1'b1;
                            regs_write_addr <= rd;
                            regs_write_data <= w_fast_res;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state         <= S_DONE;
                        regs_write_en   <= 1'b1;
                        regs_write_addr <= r_rd;
                        regs_write_data <= sel_res(r_f3, r_neg, w_acc_nxt);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
